// File: rtl/truth_table_checker_if.sv
// truth_table_checker_if: sample strobe from the stimulus side plus the checker's result bundle.
interface truth_table_checker_if;
  logic        clr;
  logic        sample_valid;
  logic [3:0]  vec;
  logic        f;
  logic [15:0] captured;
  logic [15:0] covered;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_fail;
  logic        first_fail_valid;
  logic        conflict;
  logic        done;
  logic        pass;
  modport master (
    output clr, sample_valid, vec, f,
    input  captured, covered, mismatch_cnt, first_fail, first_fail_valid, conflict, done, pass
  );
  modport slave (
    input  clr, sample_valid, vec, f,
    output captured, covered, mismatch_cnt, first_fail, first_fail_valid, conflict, done, pass
  );
endinterface

// File: rtl/truth_table_checker.sv
// truth_table_checker: builds the observed 4-input truth table from strobed samples and grades it against EXPECTED.
module truth_table_checker #(
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input logic clk,
  input logic rst_n,
  truth_table_checker_if.slave tt_if
);
  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] DONE    = 1'b1;
  logic [0:0]  state_q, state_d;
  logic [15:0] captured_q, captured_d;
  logic [15:0] covered_q, covered_d;
  logic [4:0]  mismatch_cnt_q, mismatch_cnt_d;
  logic [3:0]  first_fail_q, first_fail_d;
  logic        first_fail_valid_q, first_fail_valid_d;
  logic        conflict_q, conflict_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        hit, fresh, miss;
  always_comb begin
    hit                = tt_if.sample_valid && state_q == COLLECT;
    fresh              = hit && !covered_q[tt_if.vec];
    miss               = tt_if.f != EXPECTED[tt_if.vec];
    captured_d         = captured_q;
    covered_d          = covered_q;
    mismatch_cnt_d     = mismatch_cnt_q;
    first_fail_d       = first_fail_q;
    first_fail_valid_d = first_fail_valid_q;
    conflict_d         = conflict_q;
    if (fresh) begin
      captured_d[tt_if.vec] = tt_if.f;
      covered_d[tt_if.vec]  = 1'b1;
      mismatch_cnt_d        = miss ? mismatch_cnt_q + 5'd1 : mismatch_cnt_q;
      if (miss && !first_fail_valid_q) begin
        first_fail_d       = tt_if.vec;
        first_fail_valid_d = 1'b1;
      end
    end
    if (hit && covered_q[tt_if.vec] && tt_if.f != captured_q[tt_if.vec])
      conflict_d = 1'b1;
    state_d = &covered_d ? DONE : state_q;
    done_d  = &covered_d;
    // pass is graded on the post-sample values so it rises with done
    pass_d  = &covered_d && mismatch_cnt_d == 5'd0 && !conflict_d;
    if (tt_if.clr) begin
      state_d            = COLLECT;
      captured_d         = '0;
      covered_d          = '0;
      mismatch_cnt_d     = '0;
      first_fail_d       = '0;
      first_fail_valid_d = 1'b0;
      conflict_d         = 1'b0;
      done_d             = 1'b0;
      pass_d             = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= COLLECT;
      captured_q         <= '0;
      covered_q          <= '0;
      mismatch_cnt_q     <= '0;
      first_fail_q       <= '0;
      first_fail_valid_q <= 1'b0;
      conflict_q         <= 1'b0;
      done_q             <= 1'b0;
      pass_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      captured_q         <= captured_d;
      covered_q          <= covered_d;
      mismatch_cnt_q     <= mismatch_cnt_d;
      first_fail_q       <= first_fail_d;
      first_fail_valid_q <= first_fail_valid_d;
      conflict_q         <= conflict_d;
      done_q             <= done_d;
      pass_q             <= pass_d;
    end
  end
  assign tt_if.captured         = captured_q;
  assign tt_if.covered          = covered_q;
  assign tt_if.mismatch_cnt     = mismatch_cnt_q;
  assign tt_if.first_fail       = first_fail_q;
  assign tt_if.first_fail_valid = first_fail_valid_q;
  assign tt_if.conflict         = conflict_q;
  assign tt_if.done             = done_q;
  assign tt_if.pass             = pass_q;
endmodule
